// File: rtl/magic_cfg_bank_pkg.sv
// magic_cfg_bank_pkg: shared types and constants for the magic-mode config bank.
package magic_cfg_bank_pkg;

   // Effective CPU speed selection; every 3-bit code has a name so casts are total.
   typedef enum logic [2:0] {
      TURBO_NONE = 3'd0,
      TURBO_7    = 3'd1,
      TURBO_14   = 3'd2,
      TURBO_28   = 3'd3,
      TURBO_R4   = 3'd4,
      TURBO_R5   = 3'd5,
      TURBO_R6   = 3'd6,
      TURBO_R7   = 3'd7
   } turbo_t;

   localparam int unsigned CFG_STATUS_IDX   = 0;
   localparam logic [7:0]  CFG_PORT_DEFAULT = 8'hFF;
   localparam int unsigned CFG_MAX_REGS     = 256;
   localparam int unsigned CFG_FLAT_W       = CFG_MAX_REGS * 8;

   // Extract byte i from a flat register image (callers widen to CFG_FLAT_W).
   function automatic logic [7:0] cfg_byte(input logic [CFG_FLAT_W-1:0] flat,
                                           input int unsigned i);
      logic [10:0] lsb;
      lsb = 11'(i) << 3;
      return flat[lsb +: 8];
   endfunction

endpackage

// File: rtl/cpu_bus.sv
// cpu_bus: Z80-style CPU bus strobes, address and write data.
interface cpu_bus;
   logic        mreq;
   logic        ioreq;
   logic        rd;
   logic        wr;
   logic [15:0] a;
   logic [7:0]  d;

   modport slave  (input  mreq, ioreq, rd, wr, a, d);
   modport master (output mreq, ioreq, rd, wr, a, d);
endinterface

// File: rtl/magic_cfg_bank_autoturbo_gov.sv
// autoturbo_gov: port-FE no-turbo hold counter and effective turbo selection.
module autoturbo_gov
   import magic_cfg_bank_pkg::*;
#(
   parameter int unsigned HOLD_W = 12
) (
   input  logic       clk28_i,
   input  logic       rst_i,
   input  logic       ck35_i,
   input  logic       ioreq_i,
   input  logic       a0_i,
   input  logic       magic_map_i,
   input  logic       div_paged_i,
   input  logic       at_i,
   input  logic [2:0] sel_i,
   output turbo_t     turbo_o
);

   logic [HOLD_W-1:0] hold_q, hold_d;
   turbo_t            turbo_q, turbo_d;

   // Next hold count and turbo mode; hold runs on ck35 until it wraps back to zero.
   always_comb begin
      hold_d  = hold_q;
      turbo_d = turbo_t'(sel_i);
      if (ioreq_i && !a0_i) begin
         hold_d = HOLD_W'(1);
      end else if ((hold_q != '0) && ck35_i) begin
         hold_d = hold_q + 1'b1;
      end
      if (at_i && div_paged_i && !magic_map_i) begin
         turbo_d = TURBO_14;
      end else if (at_i && (hold_q != '0)) begin
         turbo_d = TURBO_NONE;
      end
   end

   // Hold counter and registered turbo output.
   always_ff @(posedge clk28_i) begin
      if (rst_i) begin
         hold_q  <= '0;
         turbo_q <= TURBO_NONE;
      end else begin
         hold_q  <= hold_d;
         turbo_q <= turbo_d;
      end
   end

   assign turbo_o = turbo_q;

endmodule

// File: rtl/magic_cfg_bank.sv
// magic_cfg_bank: NUM_REGS-byte register file on I/O port xxFF, accessible only
// while the magic ROM is mapped. Build macro CFG_SHADOW_EN: writes land in a
// shadow array and a write to index 0 commits the whole shadow to cfg at once.
module magic_cfg_bank
   import magic_cfg_bank_pkg::*;
#(
   parameter int unsigned           NUM_REGS     = 16,
   parameter logic [7:0]            PORT_LO      = CFG_PORT_DEFAULT,
   parameter logic [NUM_REGS*8-1:0] RESET_VALUES = {NUM_REGS{8'h00}},
   parameter int unsigned           TURBO_REG    = 3,
   parameter int unsigned           HOLD_W       = 12
) (
   input  logic                  clk28,
   input  logic                  rst,
   input  logic                  ck35,
   cpu_bus.slave                 bus,
   input  logic                  magic_map,
   input  logic                  div_paged,
   input  logic [7:0]            status_in,
   output logic [NUM_REGS*8-1:0] cfg,
   output logic [NUM_REGS-1:0]   cfg_changed,
   output logic [7:0]            d_out,
   output logic                  d_out_active,
   output turbo_t                turbo
);

   logic       cs, valid, wr_cyc, wr_cap, apply;
   logic [7:0] idx;
   logic       wr_pend_q, wr_pend_d;
   logic [7:0] wr_idx_q, wr_idx_d;
   logic [7:0] wr_data_q, wr_data_d;
   logic [7:0] d_out_q, d_out_d;
   logic       act_q, act_d;
   logic [7:0] rd_arr [CFG_MAX_REGS];
   logic       turbo_at;
   logic [2:0] turbo_sel;

   assign idx    = bus.a[15:8];
   assign cs     = magic_map && bus.ioreq && (bus.a[7:0] == PORT_LO);
   assign valid  = (32'(idx) < NUM_REGS);
   assign wr_cyc = cs && bus.wr;
`ifdef CFG_SHADOW_EN
   assign wr_cap = wr_cyc && valid;
`else
   assign wr_cap = wr_cyc && valid && (idx != 8'(CFG_STATUS_IDX));
`endif
   // The write lands once, on the first clock after the bus write strobe ends.
   assign apply  = wr_pend_q && !wr_cyc;

`ifdef CFG_SHADOW_EN
   logic commit;
   assign commit = apply && (wr_idx_q == 8'(CFG_STATUS_IDX));
`endif

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      localparam logic [7:0] RST_VAL  = cfg_byte(CFG_FLAT_W'(RESET_VALUES), g);
      localparam bit         WRITABLE = (g != CFG_STATUS_IDX);
      logic [7:0] live_q, live_d;
      logic       chg_q;
      logic       hit;

      assign hit = apply && (wr_idx_q == 8'(g));

`ifdef CFG_SHADOW_EN
      logic [7:0] shad_q, shad_d;

      // Shadow takes writes; live copy only changes on a commit.
      always_comb begin
         shad_d = shad_q;
         live_d = live_q;
         if (hit && WRITABLE) shad_d = wr_data_q;
         if (commit)          live_d = shad_q;
      end

      // Shadow byte storage.
      always_ff @(posedge clk28) begin
         if (rst) shad_q <= RST_VAL;
         else     shad_q <= shad_d;
      end

      assign rd_arr[g] = shad_q;
`else
      // Live byte takes the pending write directly.
      always_comb begin
         live_d = live_q;
         if (hit && WRITABLE) live_d = wr_data_q;
      end

      assign rd_arr[g] = live_q;
`endif

      // Live byte storage and one-clock change strobe.
      always_ff @(posedge clk28) begin
         if (rst) begin
            live_q <= RST_VAL;
            chg_q  <= 1'b0;
         end else begin
            live_q <= live_d;
            chg_q  <= (live_d != live_q);
         end
      end

      assign cfg[g*8 +: 8] = live_q;
      assign cfg_changed[g] = chg_q;

      if (g == TURBO_REG) begin : g_turbo
         assign turbo_at  = live_q[7];
         assign turbo_sel = live_q[2:0];
      end
   end

   for (genvar g = NUM_REGS; g < CFG_MAX_REGS; g++) begin : g_pad
      assign rd_arr[g] = '0;
   end

   if (TURBO_REG >= NUM_REGS) begin : g_no_turbo
      assign turbo_at  = 1'b0;
      assign turbo_sel = '0;
   end

   // Write capture and registered readback; wr wins over a simultaneous rd.
   always_comb begin
      wr_pend_d = wr_pend_q;
      wr_idx_d  = wr_idx_q;
      wr_data_d = wr_data_q;
      if (wr_cap) begin
         wr_pend_d = 1'b1;
         wr_idx_d  = idx;
         wr_data_d = bus.d;
      end else if (apply) begin
         wr_pend_d = 1'b0;
      end
      act_d   = cs && bus.rd && !bus.wr && valid;
      d_out_d = (idx == 8'(CFG_STATUS_IDX)) ? status_in : rd_arr[idx];
   end

   // Write-pending flag, captured write and readback registers.
   always_ff @(posedge clk28) begin
      if (rst) begin
         wr_pend_q <= 1'b0;
         wr_idx_q  <= '0;
         wr_data_q <= '0;
         d_out_q   <= '0;
         act_q     <= 1'b0;
      end else begin
         wr_pend_q <= wr_pend_d;
         wr_idx_q  <= wr_idx_d;
         wr_data_q <= wr_data_d;
         d_out_q   <= d_out_d;
         act_q     <= act_d;
      end
   end

   assign d_out        = d_out_q;
   assign d_out_active = act_q;

   autoturbo_gov #(
      .HOLD_W (HOLD_W)
   ) u_gov (
      .clk28_i     (clk28),
      .rst_i       (rst),
      .ck35_i      (ck35),
      .ioreq_i     (bus.ioreq),
      .a0_i        (bus.a[0]),
      .magic_map_i (magic_map),
      .div_paged_i (div_paged),
      .at_i        (turbo_at),
      .sel_i       (turbo_sel),
      .turbo_o     (turbo)
   );

endmodule

// File: tb/tb_magic_cfg_bank.sv
// tb_magic_cfg_bank: directed self-checking bench for magic_cfg_bank.
`timescale 1ns/1ps
module tb_magic_cfg_bank;
   import magic_cfg_bank_pkg::*;

   localparam int unsigned NR = 16;
   localparam int unsigned HW = 4;
   localparam logic [NR*8-1:0] RV = (128'hA5 << 40) | (128'h5A << 16);

   logic          clk28 = 1'b0;
   logic          rst = 1'b1;
   logic          ck35 = 1'b0;
   logic [2:0]    ck_div = '0;
   logic          magic_map = 1'b0;
   logic          div_paged = 1'b0;
   logic [7:0]    status_in = 8'hC3;
   logic [NR*8-1:0] cfg;
   logic [NR-1:0] cfg_changed;
   logic [7:0]    d_out;
   logic          d_out_active;
   turbo_t        turbo;

   cpu_bus bus();

   magic_cfg_bank #(
      .NUM_REGS     (NR),
      .PORT_LO      (8'hFF),
      .RESET_VALUES (RV),
      .TURBO_REG    (3),
      .HOLD_W       (HW)
   ) dut (
      .clk28        (clk28),
      .rst          (rst),
      .ck35         (ck35),
      .bus          (bus),
      .magic_map    (magic_map),
      .div_paged    (div_paged),
      .status_in    (status_in),
      .cfg          (cfg),
      .cfg_changed  (cfg_changed),
      .d_out        (d_out),
      .d_out_active (d_out_active),
      .turbo        (turbo)
   );

   always #5 clk28 = ~clk28;

   // 3.5 MHz tick: one clk28 in eight, changed away from the sampling edge.
   always @(negedge clk28) begin
      ck_div = ck_div + 3'd1;
      ck35   = (ck_div == 3'd0);
   end

   int ticks = 0;
   always @(posedge clk28) if (ck35) ticks++;

   int checks = 0;
   int errors = 0;
   logic [7:0] model  [NR];
   logic [7:0] shadow [NR];
   logic [7:0] sb_q [$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR*8-1:0] model_flat();
      logic [NR*8-1:0] f;
      for (int i = 0; i < NR; i++) f[i*8 +: 8] = model[i];
      return f;
   endfunction

   task automatic model_reset();
      logic [NR*8-1:0] rv_v;
      rv_v = RV;
      for (int i = 0; i < NR; i++) begin
         model[i]  = rv_v[i*8 +: 8];
         shadow[i] = rv_v[i*8 +: 8];
      end
   endtask

   task automatic io_write(input logic [15:0] addr, input logic [7:0] data, input int hold);
      @(negedge clk28);
      bus.a = addr; bus.d = data; bus.ioreq = 1'b1; bus.wr = 1'b1;
      repeat (hold) @(negedge clk28);
      bus.ioreq = 1'b0; bus.wr = 1'b0;
   endtask

   // Called right after io_write returns: the next edge is the apply edge.
   task automatic after_write(input string tag, input logic [NR-1:0] mask);
      @(negedge clk28);
      chk({tag, "_cfg"}, cfg, model_flat());
      chk({tag, "_strobe"}, cfg_changed, mask);
      @(negedge clk28);
      chk({tag, "_strobe_clr"}, cfg_changed, '0);
   endtask

   task automatic read_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
      logic [7:0] e;
      sb_q.push_back(exp);
      @(negedge clk28);
      bus.a = addr; bus.ioreq = 1'b1; bus.rd = 1'b1;
      @(negedge clk28);
      chk({tag, "_active"}, d_out_active, 1'b1);
      e = sb_q.pop_front();
      if (d_out_active) chk({tag, "_data"}, d_out, e);
      bus.ioreq = 1'b0; bus.rd = 1'b0;
      @(negedge clk28);
      chk({tag, "_drop"}, d_out_active, 1'b0);
   endtask

   task automatic read_none(input string tag, input logic [15:0] addr, input logic drive_wr);
      logic seen;
      seen = 1'b0;
      @(negedge clk28);
      bus.a = addr; bus.d = 8'h44; bus.ioreq = 1'b1; bus.rd = 1'b1; bus.wr = drive_wr;
      repeat (2) begin @(negedge clk28); seen = seen | d_out_active; end
      bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
      chk({tag, "_inactive"}, seen, 1'b0);
   endtask

   function automatic logic [NR-1:0] diff_mask();
      logic [NR-1:0] m;
      for (int i = 0; i < NR; i++) m[i] = (model[i] != shadow[i]);
      return m;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [NR-1:0] any_chg;
      int n;
      int t0;
      bus.mreq = 1'b0; bus.ioreq = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0;
      bus.a = '0; bus.d = '0;
      model_reset();

      // Reset state.
      repeat (3) @(negedge clk28);
      rst = 1'b0;
      chk("rst_cfg", cfg, RV);
      chk("rst_strobe", cfg_changed, '0);
      chk("rst_turbo", turbo, TURBO_NONE);
      chk("rst_active", d_out_active, 1'b0);
      chk("rst_dout", d_out, 8'h00);
      magic_map = 1'b1;

`ifdef CFG_SHADOW_EN
      // Shadow writes stay invisible until an index-0 commit.
      io_write(16'h02FF, 8'h07, 3);
      shadow[2] = 8'h07;
      after_write("sh_wr2", '0);
      read_check("sh_rb2", 16'h02FF, 8'h07);
      io_write(16'h00FF, 8'h00, 2);
      after_write("sh_commit1", diff_mask());
      model[2] = shadow[2];
      chk("sh_commit1_cfg", cfg, model_flat());
      io_write(16'h05FF, 8'h3C, 2);
      shadow[5] = 8'h3C;
      after_write("sh_wr5", '0);
      io_write(16'h02FF, 8'h5A, 2);
      shadow[2] = 8'h5A;
      after_write("sh_wr2b", '0);
      read_check("sh_rb5", 16'h05FF, 8'h3C);
      io_write(16'h00FF, 8'h00, 2);
      chk("sh_commit2_mask", diff_mask(), 16'h0024);
      any_chg = diff_mask();
      for (int i = 0; i < NR; i++) model[i] = shadow[i];
      after_write("sh_commit2", any_chg);
      read_check("sh_status", 16'h00FF, 8'hC3);
`else
      // Write lands one clock after wr drops, with a one-clock strobe.
      io_write(16'h05FF, 8'h3C, 6);
      chk("wr5_pre_apply", cfg, RV);
      model[5] = 8'h3C;
      after_write("wr5", 16'h0020);
      io_write(16'h05FF, 8'h3C, 2);
      after_write("wr5_same", '0);

      magic_map = 1'b0;
      io_write(16'h05FF, 8'h11, 2);
      after_write("wr5_unmapped", '0);
      magic_map = 1'b1;

      read_check("rd5", 16'h05FF, 8'h3C);
      read_check("rd_status", 16'h00FF, 8'hC3);
      status_in = 8'h7E;
      read_check("rd_status2", 16'h00FF, 8'h7E);
      read_check("rd2_reset", 16'h02FF, 8'h5A);

      io_write(16'h20FF, 8'h55, 2);
      after_write("wr_invalid", '0);
      read_none("rd_invalid", 16'h20FF, 1'b0);
      io_write(16'h00FF, 8'h99, 2);
      after_write("wr_idx0", '0);

      // Simultaneous rd and wr: write wins, no drive.
      read_none("rdwr", 16'h07FF, 1'b1);
      model[7] = 8'h44;
      after_write("rdwr", 16'h0080);

      // magic_map dropping with a write pending still applies it.
      @(negedge clk28);
      bus.a = 16'h08FF; bus.d = 8'h12; bus.ioreq = 1'b1; bus.wr = 1'b1;
      repeat (2) @(negedge clk28);
      bus.ioreq = 1'b0; bus.wr = 1'b0; magic_map = 1'b0;
      model[8] = 8'h12;
      after_write("wr8_unmap", 16'h0100);
      magic_map = 1'b1;
`endif

      // Reset during a write discards it without a strobe.
      @(negedge clk28);
      bus.a = 16'h06FF; bus.d = 8'h77; bus.ioreq = 1'b1; bus.wr = 1'b1;
      @(negedge clk28);
      rst = 1'b1;
      @(negedge clk28);
      bus.ioreq = 1'b0; bus.wr = 1'b0; rst = 1'b0;
      any_chg = '0;
      repeat (3) begin @(negedge clk28); any_chg = any_chg | cfg_changed; end
      model_reset();
      chk("rst_midwr_cfg", cfg, RV);
      chk("rst_midwr_strobe", any_chg, '0);

      // Auto-turbo: register 3 = autoturbo on, select TURBO_7.
      io_write(16'h03FF, 8'h81, 2);
`ifdef CFG_SHADOW_EN
      shadow[3] = 8'h81;
      after_write("wr3", '0);
      io_write(16'h00FF, 8'h00, 2);
      model[3] = 8'h81;
      after_write("wr3_commit", 16'h0008);
`else
      model[3] = 8'h81;
      after_write("wr3", 16'h0008);
`endif
      @(negedge clk28);
      chk("turbo_sel", turbo, TURBO_7);
      magic_map = 1'b0; div_paged = 1'b1;
      repeat (2) @(negedge clk28);
      chk("turbo_div", turbo, TURBO_14);
      div_paged = 1'b0;
      repeat (2) @(negedge clk28);
      chk("turbo_div_off", turbo, TURBO_7);

      bus.a = 16'h00FE; bus.ioreq = 1'b1; bus.rd = 1'b1;
      repeat (2) @(negedge clk28);
      bus.ioreq = 1'b0; bus.rd = 1'b0;
      t0 = ticks;
      chk("turbo_hold", turbo, TURBO_NONE);
      n = 0;
      while ((turbo == TURBO_NONE) && (n < 400)) begin
         @(negedge clk28);
         n++;
      end
      chk("turbo_hold_bound", (n < 400), 1'b1);
      chk("turbo_hold_ticks", ticks - t0, (1 << HW) - 1);
      chk("turbo_after_hold", turbo, TURBO_7);
      chk("final_cfg", cfg, model_flat());

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
